pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program counter for the CPU controller, successor to the fixed 3-bit free-running counter. It adds enable, absolute jump, signed relative branch, halt/resume, a configurable terminal address with wrap or stop, and an optional call/return address stack. It sits in the controller front end and drives the instruction-fetch address each cycle.

## Interface
- WIDTH, 8, PC width in bits (≥2)
- RESET_ADDR, 0, PC value after reset and after wrap
- LAST_ADDR, 2**WIDTH-1, terminal address for sequential increment
- WRAP, 1, 1: wrap to RESET_ADDR after LAST_ADDR; 0: stop and halt at LAST_ADDR
- STACK_DEPTH, 4, return-stack entries (used only with PC_STACK_EN)

- clk  in  1  rising-edge clock
- rstn  in  1  reset, asynchronous, active-low
- en  in  1  advance/command enable
- halt  in  1  request HALT state
- resume  in  1  request RUN state
- jmp  in  1  absolute jump request
- jmp_addr  in  WIDTH  jump target
- br  in  1  relative branch request
- br_off  in  WIDTH  signed two's-complement branch offset
- call  in  1  subroutine call request
- call_addr  in  WIDTH  call target
- ret  in  1  return request
- out  out  WIDTH  current PC
- running  out  1  1 in RUN, 0 in HALT
- wrapped  out  1  one-cycle pulse on LAST_ADDR→RESET_ADDR wrap
- stk_err  out  1  one-cycle pulse on stack overflow/underflow

## Operation
- Reset (rstn=0, immediate): out=RESET_ADDR, state RUN, running=1, wrapped=0, stk_err=0, stack empty.
- States: RUN, HALT.
- RUN, halt=1: → HALT, PC holds (regardless of en).
- RUN, en=0: PC holds; no command accepted.
- RUN, en=1, priority: jmp > call > ret > br > increment.
  - jmp: out←jmp_addr.
  - call: push (out+1) mod 2^WIDTH, out←call_addr.
  - ret: out←popped address.
  - br: out←(out+br_off) mod 2^WIDTH; no wrapped pulse.
  - increment: out≠LAST_ADDR → out+1. out=LAST_ADDR: WRAP=1 → out←RESET_ADDR, wrapped=1; WRAP=0 → out holds, → HALT.
- HALT: resume=1 → RUN next cycle, PC unchanged that cycle. jmp with en=1 loads jmp_addr, stays HALT. All other commands ignored. halt and resume together: halt wins.
- Stack overflow (call when full): call ignored, PC increments as normal, stk_err=1. Underflow (ret when empty): treated as increment, stk_err=1.
- Arithmetic modulo 2^WIDTH; branch offset sign-extended implicitly by width match.

## Timing
- All outputs registered; command sampled at edge N, out/running/wrapped/stk_err reflect it after edge N (one-cycle latency).
- wrapped and stk_err high exactly one cycle per event.
- Reset asserted mid-command aborts it; stack contents discarded.
- Push and pop never occur in the same cycle (priority guarantees).

## Configuration
- PC_STACK_EN defined: return stack of STACK_DEPTH entries, call/ret behave as above.
- Undefined: no stack storage; call and ret ignored (cycle treated as increment if no higher command), stk_err tied 0.

## Structure
- Package pc_pkg: state enum (RUN, HALT), command-select enum (CMD_NONE, CMD_JMP, CMD_CALL, CMD_RET, CMD_BR, CMD_INC).
- Sub-module pc_stack: LIFO with push/pop/full/empty, instantiated only under PC_STACK_EN.

## Test plan
- WIDTH=3, WRAP=1: reset, en=1 for 9 cycles → out 0,1,…,7,0; wrapped pulses once at 7→0.
- WIDTH=3, WRAP=0: increment from 0 → out stops at 7, running→0; resume → running=1, next increment holds at 7 and halts again.
- jmp_addr=5 with br=1 same cycle → out=5; then br_off=3'b110 (−2) → out=3.
- PC_STACK_EN, STACK_DEPTH=2: at out=1 call 6 → out=6; ret → out=2; ret on empty → out=3, stk_err pulse; three calls → third gives stk_err, PC increments.
- halt at out=4 with en=1 → out stays 4 for 3 cycles, jmp 2 in HALT → out=2, running=0; resume → counting from 2.
- rstn low mid-run at out=6 → out=0 immediately (before next edge), running=1, stack empty.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: run/halt state and the
// command selected for the current cycle.
package pc_pkg;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_STACK_DEPTH = 4;

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_JMP  = 3'd1,
    CMD_CALL = 3'd2,
    CMD_RET  = 3'd3,
    CMD_BR   = 3'd4,
    CMD_INC  = 3'd5
  } cmd_e;

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO for call/ret; the top entry is readable combinationally.
module pc_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_STACK_DEPTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mem [2**AW];

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign top   = mem[AW'(cnt_q - CW'(1))];

  // Occupancy count; reset discards all entries.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[AW'(cnt_q)] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with enable, jump, relative branch, halt/resume and terminal
// wrap/stop. Define PC_STACK_EN to add the call/return address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned RESET_ADDR  = 0,
  parameter int unsigned LAST_ADDR   = 2**WIDTH - 1,
  parameter bit          WRAP        = 1'b1,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             halt,
  input  logic             resume,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_addr,
  input  logic             br,
  input  logic [WIDTH-1:0] br_off,
  input  logic             call,
  input  logic [WIDTH-1:0] call_addr,
  input  logic             ret,
  output logic [WIDTH-1:0] out,
  output logic             running,
  output logic             wrapped,
  output logic             stk_err
);

  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_ADDR);
  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST_ADDR);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             wrapped_q, wrapped_d;
  logic             stk_err_q, stk_err_d;
  cmd_e             cmd;
  logic             stk_bad;
  logic             stk_full;
  logic             stk_empty;
  logic [WIDTH-1:0] stk_top;

`ifdef PC_STACK_EN
  localparam bit STK_EN = 1'b1;

  pc_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rstn      (rstn),
    .push      (cmd == CMD_CALL),
    .pop       (cmd == CMD_RET),
    .push_data (pc_q + ONE),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );
`else
  localparam bit STK_EN = 1'b0;

  // Without storage the stack looks permanently full and empty, so call and
  // ret fall through to a plain increment; the error pulse is masked.
  logic unused_depth;
  assign unused_depth = ^STACK_DEPTH;
  assign stk_full     = 1'b1;
  assign stk_empty    = 1'b1;
  assign stk_top      = '0;
`endif

  // Select the RUN-mode command for this cycle (jmp > call > ret > br > inc).
  always_comb begin
    cmd     = CMD_NONE;
    stk_bad = 1'b0;
    if (state_q == RUN && !halt && en) begin
      if (jmp) begin
        cmd = CMD_JMP;
      end else if (call) begin
        cmd     = stk_full ? CMD_INC : CMD_CALL;
        stk_bad = stk_full;
      end else if (ret) begin
        cmd     = stk_empty ? CMD_INC : CMD_RET;
        stk_bad = stk_empty;
      end else if (br) begin
        cmd = CMD_BR;
      end else begin
        cmd = CMD_INC;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wrapped_d = 1'b0;
    stk_err_d = stk_bad & STK_EN;
    unique case (state_q)
      RUN: begin
        if (halt) begin
          state_d = HALT;
        end else begin
          unique case (cmd)
            CMD_JMP:  pc_d = jmp_addr;
            CMD_CALL: pc_d = call_addr;
            CMD_RET:  pc_d = stk_top;
            CMD_BR:   pc_d = pc_q + br_off;
            CMD_INC: begin
              if (pc_q != LAST_V) begin
                pc_d = pc_q + ONE;
              end else if (WRAP) begin
                pc_d      = RST_V;
                wrapped_d = 1'b1;
              end else begin
                state_d = HALT;
              end
            end
            default: ;
          endcase
        end
      end
      HALT: begin
        if (resume && !halt) begin
          state_d = RUN;
        end else if (en && jmp) begin
          pc_d = jmp_addr;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= RUN;
      pc_q      <= RST_V;
      wrapped_q <= 1'b0;
      stk_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      wrapped_q <= wrapped_d;
      stk_err_q <= stk_err_d;
    end
  end

  assign out     = pc_q;
  assign running = (state_q == RUN);
  assign wrapped = wrapped_q;
  assign stk_err = stk_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a wrapping and a stopping 3-bit instance share the
// stimulus and are checked every cycle against an integer reference model.
module tb_pc_sequencer;

`ifdef PC_STACK_EN
  localparam bit HAS_STK = 1'b1;
`else
  localparam bit HAS_STK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       en, halt, resume, jmp, br, call, ret;
  logic [2:0] jmp_addr, br_off, call_addr;

  logic [2:0] out_w, out_s;
  logic       running_w, running_s, wrapped_w, wrapped_s, stk_err_w, stk_err_s;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;
  int nwr;

  // Reference state per instance: index 0 wraps, index 1 stops.
  int m_pc  [2];
  bit m_run [2];
  bit m_wr  [2];
  bit m_err [2];
  int s_dat [2][2];
  int s_cnt [2];

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH(3), .RESET_ADDR(0), .LAST_ADDR(7), .WRAP(1'b1), .STACK_DEPTH(2)
  ) u_wrap (
    .clk(clk), .rstn(rstn), .en(en), .halt(halt), .resume(resume),
    .jmp(jmp), .jmp_addr(jmp_addr), .br(br), .br_off(br_off),
    .call(call), .call_addr(call_addr), .ret(ret),
    .out(out_w), .running(running_w), .wrapped(wrapped_w), .stk_err(stk_err_w)
  );

  pc_sequencer #(
    .WIDTH(3), .RESET_ADDR(0), .LAST_ADDR(7), .WRAP(1'b0), .STACK_DEPTH(2)
  ) u_stop (
    .clk(clk), .rstn(rstn), .en(en), .halt(halt), .resume(resume),
    .jmp(jmp), .jmp_addr(jmp_addr), .br(br), .br_off(br_off),
    .call(call), .call_addr(call_addr), .ret(ret),
    .out(out_s), .running(running_s), .wrapped(wrapped_s), .stk_err(stk_err_s)
  );

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    en = 1'b0; halt = 1'b0; resume = 1'b0; jmp = 1'b0; br = 1'b0;
    call = 1'b0; ret = 1'b0; jmp_addr = 3'd0; br_off = 3'd0; call_addr = 3'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: spec rules applied with integer arithmetic mod 8.
  always @(posedge clk or negedge rstn) begin
    for (int d = 0; d < 2; d++) begin
      if (!rstn) begin
        m_pc[d] = 0; m_run[d] = 1'b1; m_wr[d] = 1'b0; m_err[d] = 1'b0; s_cnt[d] = 0;
      end else begin
        bit inc;
        inc = 1'b0;
        m_wr[d]  = 1'b0;
        m_err[d] = 1'b0;
        if (m_run[d]) begin
          if (halt) begin
            m_run[d] = 1'b0;
          end else if (en) begin
            if (jmp) begin
              m_pc[d] = int'(jmp_addr);
            end else if (call) begin
              if (HAS_STK && s_cnt[d] < 2) begin
                s_dat[d][s_cnt[d]] = (m_pc[d] + 1) % 8;
                s_cnt[d]++;
                m_pc[d] = int'(call_addr);
              end else begin
                m_err[d] = HAS_STK;
                inc = 1'b1;
              end
            end else if (ret) begin
              if (HAS_STK && s_cnt[d] > 0) begin
                s_cnt[d]--;
                m_pc[d] = s_dat[d][s_cnt[d]];
              end else begin
                m_err[d] = HAS_STK;
                inc = 1'b1;
              end
            end else if (br) begin
              m_pc[d] = (m_pc[d] + int'(br_off)) % 8;
            end else begin
              inc = 1'b1;
            end
          end
        end else if (resume && !halt) begin
          m_run[d] = 1'b1;
        end else if (en && jmp) begin
          m_pc[d] = int'(jmp_addr);
        end
        if (inc) begin
          if (m_pc[d] != 7) m_pc[d] = m_pc[d] + 1;
          else if (d == 0) begin m_pc[d] = 0; m_wr[d] = 1'b1; end
          else m_run[d] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("w.out",     int'(out_w),     m_pc[0]);
      cmp("w.running", int'(running_w), int'(m_run[0]));
      cmp("w.wrapped", int'(wrapped_w), int'(m_wr[0]));
      cmp("w.stk_err", int'(stk_err_w), int'(m_err[0]));
      cmp("s.out",     int'(out_s),     m_pc[1]);
      cmp("s.running", int'(running_s), int'(m_run[1]));
      cmp("s.wrapped", int'(wrapped_s), int'(m_wr[1]));
      cmp("s.stk_err", int'(stk_err_s), int'(m_err[1]));
    end
  end

  initial begin
    idle();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1 chk_on = 1'b1;
    tick(); tick();
    cmp("rst_out",     int'(out_w), 0);
    cmp("rst_running", int'(running_w), 1);
    cmp("rst_wrapped", int'(wrapped_w), 0);
    cmp("rst_stk_err", int'(stk_err_w), 0);
    rstn = 1'b1;

    // Free-running count through the terminal address
    en = 1'b1; nwr = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      nwr += int'(wrapped_w);
      if (i == 7) begin
        cmp("inc_w7", int'(out_w), 7);
        cmp("inc_s7", int'(out_s), 7);
      end
      if (i == 8) begin
        cmp("wrap_out",   int'(out_w), 0);
        cmp("wrap_pulse", int'(wrapped_w), 1);
        cmp("stop_out",   int'(out_s), 7);
        cmp("stop_halt",  int'(running_s), 0);
      end
    end
    cmp("wrap_count", nwr, 1);
    cmp("inc_w9", int'(out_w), 1);

    // Resume at the terminal address halts again on the next increment
    idle(); resume = 1'b1; tick();
    cmp("resume_run", int'(running_s), 1);
    cmp("resume_pc",  int'(out_s), 7);
    cmp("en0_hold",   int'(out_w), 1);
    idle(); en = 1'b1; tick();
    cmp("rehalt",    int'(running_s), 0);
    cmp("rehalt_pc", int'(out_s), 7);

    // jmp beats br; then a negative branch
    idle(); en = 1'b1; jmp = 1'b1; jmp_addr = 3'd5; br = 1'b1; br_off = 3'd3; tick();
    cmp("jmp_over_br", int'(out_w), 5);
    cmp("halt_jmp",    int'(out_s), 5);
    idle(); en = 1'b1; br = 1'b1; br_off = 3'b110; tick();
    cmp("br_neg",      int'(out_w), 3);
    cmp("halt_no_br",  int'(out_s), 5);

    // Halt at 4, jump while halted, resume and count on
    idle(); resume = 1'b1; tick();
    idle(); en = 1'b1; jmp = 1'b1; jmp_addr = 3'd4; tick();
    idle(); en = 1'b1; halt = 1'b1; tick();
    cmp("halt_pc",  int'(out_w), 4);
    cmp("halt_run", int'(running_w), 0);
    idle(); en = 1'b1; tick(); tick();
    cmp("halt_hold", int'(out_w), 4);
    idle(); en = 1'b1; jmp = 1'b1; jmp_addr = 3'd2; tick();
    cmp("halt_jmp2",     int'(out_w), 2);
    cmp("halt_jmp2_run", int'(running_w), 0);
    idle(); resume = 1'b1; tick();
    cmp("resume2_run", int'(running_w), 1);
    cmp("resume2_pc",  int'(out_w), 2);
    idle(); en = 1'b1; tick(); tick();
    cmp("count_from2", int'(out_w), 4);

    // Call / return
    idle(); en = 1'b1; jmp = 1'b1; jmp_addr = 3'd1; tick();
    idle(); en = 1'b1; call = 1'b1; call_addr = 3'd6; tick();
    cmp("call_pc", int'(out_w), HAS_STK ? 6 : 2);
    idle(); en = 1'b1; ret = 1'b1; tick();
    cmp("ret_pc", int'(out_w), HAS_STK ? 2 : 3);
    tick();
    cmp("underflow_pc",  int'(out_w), HAS_STK ? 3 : 4);
    cmp("underflow_err", int'(stk_err_w), HAS_STK ? 1 : 0);
    idle(); tick();
    cmp("err_oneshot", int'(stk_err_w), 0);
    idle(); en = 1'b1; call = 1'b1; call_addr = 3'd6; tick(); tick(); tick();
    cmp("overflow_pc",  int'(out_w), 7);
    cmp("overflow_err", int'(stk_err_w), HAS_STK ? 1 : 0);
    idle(); en = 1'b1; ret = 1'b1; tick();

    // Asynchronous reset mid-run
    idle(); en = 1'b1; jmp = 1'b1; jmp_addr = 3'd6; tick();
    cmp("pre_rst_pc", int'(out_w), 6);
    idle(); en = 1'b1;
    #2 rstn = 1'b0;
    #1;
    cmp("async_rst_w",   int'(out_w), 0);
    cmp("async_rst_run", int'(running_w), 1);
    cmp("async_rst_s",   int'(out_s), 0);
    tick();
    rstn = 1'b1;
    idle(); en = 1'b1; ret = 1'b1; tick();
    cmp("post_rst_pc",  int'(out_w), 1);
    cmp("post_rst_err", int'(stk_err_w), HAS_STK ? 1 : 0);
    idle(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
